// File: rtl/l1d_data_ram_arb_if.sv
// Bundle of the arbiter's requester, RAM-macro and return-path signals.
// slave : arbiter side (drives *_rdy, ram_* and the return channels)
// master: environment side (requesters, RAM macro, evict buffer)
//   lf_pld  [84:0] = {way[3:0], index[3:0], offset[1:0], sb_pld[9:0], wr_data[63:0], wr_last}
//   ev_pld  [14:0] = {tag[3:0], way[3:0], index[3:0], offset[1:0], rd_last}
//   rw_pld  [92:0] = {way[3:0], index[3:0], offset[1:0], op_is_read, wr_data[63:0], wr_data_be[7:0], sb_pld[9:0]}
//   ev_dat_pld [78:0] = {tag[3:0], way[3:0], index[3:0], offset[1:0], data[63:0], rd_last}
interface l1d_data_ram_arb_if;
  logic        lf_vld;
  logic        lf_rdy;
  logic [84:0] lf_pld;
  logic        ev_vld;
  logic        ev_rdy;
  logic [14:0] ev_pld;
  logic        rw_vld;
  logic        rw_rdy;
  logic [92:0] rw_pld;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_wbe;
  logic [63:0] ram_rdata;
  logic        rd_rsp_vld;
  logic [63:0] rd_rsp_data;
  logic [9:0]  rd_rsp_sb;
  logic        ev_dat_vld;
  logic [78:0] ev_dat_pld;
  logic        credit_ret;

  modport slave (
    input  lf_vld, lf_pld, ev_vld, ev_pld, rw_vld, rw_pld, ram_rdata, credit_ret,
    output lf_rdy, ev_rdy, rw_rdy, ram_en, ram_we, ram_addr, ram_wdata, ram_wbe,
           rd_rsp_vld, rd_rsp_data, rd_rsp_sb, ev_dat_vld, ev_dat_pld
  );

  modport master (
    output lf_vld, lf_pld, ev_vld, ev_pld, rw_vld, rw_pld, ram_rdata, credit_ret,
    input  lf_rdy, ev_rdy, rw_rdy, ram_en, ram_we, ram_addr, ram_wdata, ram_wbe,
           rd_rsp_vld, rd_rsp_data, rd_rsp_sb, ev_dat_vld, ev_dat_pld
  );
endinterface

// File: rtl/l1d_data_ram_arb.sv
// Arbiter/sequencer for the single-port L1D data RAM (64b x 256): linefill writes,
// evict burst reads and hit rd/wr share one access per cycle; grant drives ram_* in the same cycle.
// Ports: clk, rst (async, active-high), bus (slave modport: lf/ev/rw requests, RAM macro,
// hit-read return, credited evict-data return, credit_ret). Read data returns 1 cycle after issue.
module l1d_data_ram_arb #(
  parameter int CREDIT_NUM = 4,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_W     = 8
) (
  input logic              clk,
  input logic              rst,
  l1d_data_ram_arb_if.slave bus
);
  localparam int CW = $clog2(CREDIT_NUM + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_NUM);
  localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, LF_BURST = 2'd1, EV_BURST = 2'd2} state_t;

  state_t        state_q;
  logic [CW-1:0] credit_q;
  logic [SW-1:0] starve_q;
  logic          rd_pend_q;
  logic [9:0]    rd_sb_q;
  logic          ev_pend_q;
  logic [14:0]   ev_meta_q;

  logic lf_gnt, ev_gnt, rw_gnt;

  // Lowest set bit wins; a non-one-hot way is flagged by the assertions below.
  function automatic logic [1:0] way_enc(input logic [3:0] w);
    if (w[0])      return 2'd0;
    else if (w[1]) return 2'd1;
    else if (w[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  wire        lf_last = bus.lf_pld[0];
  wire        ev_last = bus.ev_pld[0];
  wire        rw_rd   = bus.rw_pld[82];
  wire        has_crd = (credit_q != '0);

  wire [ADDR_W-1:0] lf_addr = {way_enc(bus.lf_pld[84:81]), bus.lf_pld[80:77], bus.lf_pld[76:75]};
  wire [ADDR_W-1:0] ev_addr = {way_enc(bus.ev_pld[10:7]),  bus.ev_pld[6:3],   bus.ev_pld[2:1]};
  wire [ADDR_W-1:0] rw_addr = {way_enc(bus.rw_pld[92:89]), bus.rw_pld[88:85], bus.rw_pld[84:83]};

  // Grants are combinational; held at zero while reset is asserted so outputs drop at once.
  always_comb begin
    lf_gnt = 1'b0;
    ev_gnt = 1'b0;
    rw_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (starve_q >= STARVE_TOP && bus.rw_vld) rw_gnt = 1'b1;
          else if (bus.lf_vld)                      lf_gnt = 1'b1;
          else if (bus.ev_vld && has_crd)           ev_gnt = 1'b1;
          else if (bus.rw_vld)                      rw_gnt = 1'b1;
        end
        LF_BURST: lf_gnt = bus.lf_vld;
        EV_BURST: ev_gnt = bus.ev_vld && has_crd;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ram_en    = lf_gnt | ev_gnt | rw_gnt;
    bus.ram_we    = lf_gnt | (rw_gnt & ~rw_rd);
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_wbe   = '0;
    if (lf_gnt) begin
      bus.ram_addr  = lf_addr;
      bus.ram_wdata = bus.lf_pld[64:1];
      bus.ram_wbe   = 8'hFF;
    end else if (ev_gnt) begin
      bus.ram_addr  = ev_addr;
    end else if (rw_gnt) begin
      bus.ram_addr  = rw_addr;
      if (!rw_rd) begin
        bus.ram_wdata = bus.rw_pld[81:18];
        bus.ram_wbe   = bus.rw_pld[17:10];
      end
    end
  end

  assign bus.lf_rdy      = lf_gnt;
  assign bus.ev_rdy      = ev_gnt;
  assign bus.rw_rdy      = rw_gnt;
  assign bus.rd_rsp_vld  = rd_pend_q;
  assign bus.rd_rsp_data = rd_pend_q ? bus.ram_rdata : '0;
  assign bus.rd_rsp_sb   = rd_sb_q;
  assign bus.ev_dat_vld  = ev_pend_q;
  assign bus.ev_dat_pld  = ev_pend_q ? {ev_meta_q[14:1], bus.ram_rdata, ev_meta_q[0]} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      credit_q  <= CREDIT_FULL;
      starve_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_sb_q   <= '0;
      ev_pend_q <= 1'b0;
      ev_meta_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lf_gnt && !lf_last)      state_q <= LF_BURST;
          else if (ev_gnt && !ev_last) state_q <= EV_BURST;
        end
        LF_BURST: if (lf_gnt && lf_last) state_q <= IDLE;
        EV_BURST: if (ev_gnt && ev_last) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase

      // A grant and a return in the same cycle cancel; a return at full count is dropped.
      if (ev_gnt && !bus.credit_ret)
        credit_q <= credit_q - 1'b1;
      else if (bus.credit_ret && !ev_gnt && credit_q != CREDIT_FULL)
        credit_q <= credit_q + 1'b1;

      // Counts through bursts too, but only the IDLE grant logic looks at it.
      if (!bus.rw_vld || rw_gnt)     starve_q <= '0;
      else if (starve_q != STARVE_TOP) starve_q <= starve_q + 1'b1;

      rd_pend_q <= rw_gnt & rw_rd;
      rd_sb_q   <= (rw_gnt & rw_rd) ? bus.rw_pld[9:0] : '0;
      ev_pend_q <= ev_gnt;
      ev_meta_q <= ev_gnt ? bus.ev_pld : '0;
    end
  end

  a_lf_onehot: assert property (@(posedge clk) disable iff (rst) lf_gnt |-> $onehot(bus.lf_pld[84:81]));
  a_ev_onehot: assert property (@(posedge clk) disable iff (rst) ev_gnt |-> $onehot(bus.ev_pld[10:7]));
  a_rw_onehot: assert property (@(posedge clk) disable iff (rst) rw_gnt |-> $onehot(bus.rw_pld[92:89]));
  a_crd_ovf:   assert property (@(posedge clk) disable iff (rst)
                 !(bus.credit_ret && !ev_gnt && credit_q == CREDIT_FULL));
endmodule

// File: tb/tb_l1d_data_ram_arb.sv
module tb_l1d_data_ram_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l1d_data_ram_arb_if bus();
  l1d_data_ram_arb dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        lf_vld;
    logic [84:0] lf_pld;
    logic        ev_vld;
    logic [14:0] ev_pld;
    logic        rw_vld;
    logic [92:0] rw_pld;
    logic        cr;
    logic [2:0]  gnt;   // {lf, ev, rw}
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wbe;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [9:0]  rd_q[$];
  logic [14:0] ev_q[$];

  function automatic logic [84:0] mk_lf(logic [3:0] w, logic [3:0] i, logic [1:0] o, logic [63:0] d, logic last);
    return {w, i, o, 10'h000, d, last};
  endfunction
  function automatic logic [14:0] mk_ev(logic [3:0] t, logic [3:0] w, logic [3:0] i, logic [1:0] o, logic last);
    return {t, w, i, o, last};
  endfunction
  function automatic logic [92:0] mk_rw(logic [3:0] w, logic [3:0] i, logic [1:0] o, logic rd,
                                        logic [63:0] d, logic [7:0] be, logic [9:0] sb);
    return {w, i, o, rd, d, be, sb};
  endfunction
  function automatic vec_t mkv(logic lv, logic [84:0] lp, logic ev, logic [14:0] ep, logic rv, logic [92:0] rp,
                               logic cr, logic [2:0] g, logic we, logic [7:0] a, logic [7:0] be);
    vec_t v;
    v.lf_vld = lv; v.lf_pld = lp; v.ev_vld = ev; v.ev_pld = ep; v.rw_vld = rv; v.rw_pld = rp;
    v.cr = cr; v.gnt = g; v.we = we; v.addr = a; v.wbe = be;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Registered return channels: whatever was issued last cycle must show up now, nothing else.
  task automatic check_rsp();
    logic [14:0] m;
    chk("rd_rsp_vld", 128'(bus.rd_rsp_vld), 128'(rd_q.size() != 0));
    if (rd_q.size() != 0) begin
      chk("rd_rsp_sb",   128'(bus.rd_rsp_sb),   128'(rd_q[0]));
      chk("rd_rsp_data", 128'(bus.rd_rsp_data), 128'(bus.ram_rdata));
      void'(rd_q.pop_front());
    end
    chk("ev_dat_vld", 128'(bus.ev_dat_vld), 128'(ev_q.size() != 0));
    if (ev_q.size() != 0) begin
      m = ev_q.pop_front();
      chk("ev_dat_pld", 128'(bus.ev_dat_pld), 128'({m[14:1], bus.ram_rdata, m[0]}));
    end
  endtask

  task automatic cyc(input vec_t v);
    @(negedge clk);
    check_rsp();
    bus.lf_vld = v.lf_vld; bus.lf_pld = v.lf_pld;
    bus.ev_vld = v.ev_vld; bus.ev_pld = v.ev_pld;
    bus.rw_vld = v.rw_vld; bus.rw_pld = v.rw_pld;
    bus.credit_ret = v.cr;
    bus.ram_rdata = {$urandom, $urandom};
    #1;
    chk("grant", 128'({bus.lf_rdy, bus.ev_rdy, bus.rw_rdy}), 128'(v.gnt));
    chk("ram_en", 128'(bus.ram_en), 128'(v.gnt != 3'b000));
    if (v.gnt != 3'b000) begin
      chk("ram_we",   128'(bus.ram_we),   128'(v.we));
      chk("ram_addr", 128'(bus.ram_addr), 128'(v.addr));
      chk("ram_wbe",  128'(bus.ram_wbe),  128'(v.wbe));
      if (v.we) chk("ram_wdata", 128'(bus.ram_wdata), 128'(v.gnt[2] ? v.lf_pld[64:1] : v.rw_pld[81:18]));
    end
    if (v.gnt[0] && v.rw_pld[82]) rd_q.push_back(v.rw_pld[9:0]);
    if (v.gnt[1]) ev_q.push_back(v.ev_pld);
  endtask

  vec_t tbl[$];
  vec_t z;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [92:0] rwp;
    logic [84:0] lfp;
    logic [14:0] evp;
    z = mkv(0, '0, 0, '0, 0, '0, 0, 3'b000, 0, 8'h00, 8'h00);
    bus.lf_vld = 0; bus.lf_pld = '0; bus.ev_vld = 0; bus.ev_pld = '0;
    bus.rw_vld = 0; bus.rw_pld = '0; bus.credit_ret = 0; bus.ram_rdata = '0;

    // Reset state, with requests asserted to show grants stay low during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.lf_vld = 1; bus.rw_vld = 1; bus.lf_pld = mk_lf(4'b0001, 4'h0, 2'd0, 64'h1, 1'b1);
    #1;
    chk("rst_ram_en", 128'(bus.ram_en), 128'(0));
    chk("rst_grant",  128'({bus.lf_rdy, bus.ev_rdy, bus.rw_rdy}), 128'(0));
    chk("rst_rsp",    128'({bus.rd_rsp_vld, bus.ev_dat_vld}), 128'(0));
    chk("rst_credit", 128'(dut.credit_q), 128'(4));
    chk("rst_starve", 128'(dut.starve_q), 128'(0));
    bus.lf_vld = 0; bus.rw_vld = 0;
    rst = 0;

    // Single-cycle table from IDLE.
    tbl.push_back(z);
    tbl.push_back(mkv(0, '0, 0, '0, 1, mk_rw(4'b0100, 4'h3, 2'd1, 0, 64'hDEAD_BEEF_0123_4567, 8'h0F, 10'h011),
                      0, 3'b001, 1, 8'h8D, 8'h0F));
    tbl.push_back(mkv(0, '0, 0, '0, 1, mk_rw(4'b0001, 4'h5, 2'd2, 1, 64'h0, 8'h00, 10'h155),
                      0, 3'b001, 0, 8'h16, 8'h00));
    tbl.push_back(z);
    tbl.push_back(z);
    tbl.push_back(mkv(1, mk_lf(4'b1000, 4'hF, 2'd3, 64'hA5A5_0000_FFFF_1234, 1),
                      1, mk_ev(4'hA, 4'b0010, 4'h2, 2'd0, 1),
                      1, mk_rw(4'b0001, 4'h1, 2'd0, 1, 64'h0, 8'h00, 10'h001),
                      0, 3'b100, 1, 8'hFF, 8'hFF));
    tbl.push_back(mkv(0, '0, 1, mk_ev(4'hA, 4'b0010, 4'h2, 2'd0, 1),
                      1, mk_rw(4'b0001, 4'h1, 2'd0, 1, 64'h0, 8'h00, 10'h001),
                      0, 3'b010, 0, 8'h48, 8'h00));
    tbl.push_back(mkv(0, '0, 0, '0, 1, mk_rw(4'b0010, 4'h7, 2'd3, 1, 64'h0, 8'h00, 10'h2C3),
                      0, 3'b001, 0, 8'h5F, 8'h00));
    tbl.push_back(mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, 0, 8'h00, 8'h00));
    tbl.push_back(z);
    foreach (tbl[k]) cyc(tbl[k]);
    chk("credit_after_tbl", 128'(dut.credit_q), 128'(4));

    // T3: linefill burst with gaps locks out a waiting rw; rw wins the cycle after wr_last.
    rwp = mk_rw(4'b0100, 4'h1, 2'd0, 1, 64'h0, 8'h00, 10'h003);
    for (int b = 0, c = 0; b < 4; c++) begin
      if (c % 2 == 1) cyc(mkv(0, '0, 0, '0, 1, rwp, 0, 3'b000, 0, 8'h00, 8'h00));
      else begin
        lfp = mk_lf(4'b0001, 4'h4, 2'(b), {32'hC0DE, 32'(b)}, b == 3);
        cyc(mkv(1, lfp, 0, '0, 1, rwp, 0, 3'b100, 1, 8'h10 + 8'(b), 8'hFF));
        b++;
      end
    end
    cyc(mkv(0, '0, 0, '0, 1, rwp, 0, 3'b001, 0, 8'h84, 8'h00));
    cyc(z);

    // T4: 4-beat evict drains credits, next evict stalls, one credit buys exactly one beat.
    for (int b = 0; b < 4; b++)
      cyc(mkv(0, '0, 1, mk_ev(4'h5, 4'b1000, 4'h9, 2'(b), b == 3), 0, '0, 0, 3'b010, 0, 8'hE4 + 8'(b), 8'h00));
    evp = mk_ev(4'h6, 4'b1000, 4'hA, 2'd0, 0);
    cyc(mkv(0, '0, 1, evp, 0, '0, 0, 3'b000, 0, 8'h00, 8'h00));
    chk("credit_zero", 128'(dut.credit_q), 128'(0));
    cyc(mkv(0, '0, 1, evp, 0, '0, 0, 3'b000, 0, 8'h00, 8'h00));
    cyc(mkv(0, '0, 1, evp, 0, '0, 1, 3'b000, 0, 8'h00, 8'h00));
    cyc(mkv(0, '0, 1, evp, 0, '0, 0, 3'b010, 0, 8'hE8, 8'h00));
    evp = mk_ev(4'h6, 4'b1000, 4'hA, 2'd1, 0);
    cyc(mkv(0, '0, 1, evp, 0, '0, 0, 3'b000, 0, 8'h00, 8'h00));
    cyc(mkv(0, '0, 1, evp, 0, '0, 1, 3'b000, 0, 8'h00, 8'h00));
    evp = mk_ev(4'h6, 4'b1000, 4'hA, 2'd1, 1);
    cyc(mkv(0, '0, 1, evp, 0, '0, 0, 3'b010, 0, 8'hE9, 8'h00));
    repeat (4) cyc(mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, 0, 8'h00, 8'h00));
    cyc(z);
    chk("credit_restored", 128'(dut.credit_q), 128'(4));

    // T5: continuous linefill bursts starve rw; rw jumps ahead at the IDLE after 8 bypassed cycles.
    rwp = mk_rw(4'b0001, 4'h0, 2'd0, 1, 64'h0, 8'h00, 10'h02A);
    for (int c = 0; c < 8; c++) begin
      lfp = mk_lf(4'b0010, 4'h6, 2'(c % 4), 64'(c), (c % 4) == 3);
      cyc(mkv(1, lfp, 0, '0, 1, rwp, 0, 3'b100, 1, 8'h58 + 8'(c % 4), 8'hFF));
    end
    lfp = mk_lf(4'b0010, 4'h6, 2'd0, 64'h99, 1);
    cyc(mkv(1, lfp, 0, '0, 1, rwp, 0, 3'b001, 0, 8'h00, 8'h00));
    cyc(mkv(1, lfp, 0, '0, 0, '0, 0, 3'b100, 1, 8'h58, 8'hFF));
    cyc(z);

    // T6: reset in the middle of an evict burst, with a read return in flight.
    cyc(mkv(0, '0, 1, mk_ev(4'h3, 4'b0001, 4'h2, 2'd0, 0), 0, '0, 0, 3'b010, 0, 8'h08, 8'h00));
    cyc(mkv(0, '0, 1, mk_ev(4'h3, 4'b0001, 4'h2, 2'd1, 0), 0, '0, 0, 3'b010, 0, 8'h09, 8'h00));
    @(posedge clk);
    #2;
    bus.ev_pld = mk_ev(4'h3, 4'b0001, 4'h2, 2'd2, 0);
    chk("pre_rst_ev_dat_vld", 128'(bus.ev_dat_vld), 128'(1));
    rst = 1;
    rd_q.delete();
    ev_q.delete();
    #1;
    chk("mid_rst_ev_dat_vld", 128'(bus.ev_dat_vld), 128'(0));
    chk("mid_rst_ev_rdy",     128'(bus.ev_rdy),     128'(0));
    chk("mid_rst_ram_en",     128'(bus.ram_en),     128'(0));
    chk("mid_rst_credit",     128'(dut.credit_q),   128'(4));
    chk("mid_rst_state",      128'(dut.state_q),    128'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    bus.ev_vld = 0;
    cyc(z);
    cyc(mkv(0, '0, 1, mk_ev(4'h7, 4'b0100, 4'hB, 2'd2, 1), 0, '0, 0, 3'b010, 0, 8'hAE, 8'h00));
    cyc(mkv(0, '0, 0, '0, 0, '0, 1, 3'b000, 0, 8'h00, 8'h00));
    cyc(z);
    chk("final_credit", 128'(dut.credit_q), 128'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
